// File: rtl/idu_stage.sv
// Instruction decode stage: one-deep registered skid between IFU and EXU.
// Decodes RV32I/RV32E base opcodes into a control bundle; halts after handing over ebreak.
module idu_stage #(
   parameter int unsigned NR_REG = 16,
   parameter int unsigned CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [31:0]      in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_pc,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [31:0]      imm,
   output logic [3:0]       alu_op,
   output logic [2:0]       funct3,
   output logic [7:0]       ctl,
   output logic             illegal,
   output logic             stop_sim,
   output logic             halted,
   output logic [CNT_W-1:0] dec_cnt
);

   typedef enum logic [1:0] {StEmpty, StFull, StHalt} state_e;

   localparam logic [6:0] OpImm = 7'b0010011, OpReg = 7'b0110011, OpLui = 7'b0110111;
   localparam logic [6:0] OpAuipc = 7'b0010111, OpJal = 7'b1101111, OpJalr = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011, OpLoad = 7'b0000011, OpStore = 7'b0100011;

   localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluSll = 4'd2, AluSlt = 4'd3;
   localparam logic [3:0] AluSltu = 4'd4, AluXor = 4'd5, AluSrl = 4'd6, AluSra = 4'd7;
   localparam logic [3:0] AluOr = 4'd8, AluAnd = 4'd9, AluPassB = 4'd10;

   localparam logic [7:0] CtlRegWen = 8'h01, CtlSrc1Pc = 8'h02, CtlSrc2Imm = 8'h04;
   localparam logic [7:0] CtlMemRen = 8'h08, CtlMemWen = 8'h10, CtlBranch = 8'h20;
   localparam logic [7:0] CtlJump = 8'h40, CtlMemToReg = 8'h80;

   state_e state_q, state_d;

   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [3:0]  alu_f3;
   logic [4:0]  d_rs1, d_rs2, d_rd;
   logic [31:0] d_imm;
   logic [3:0]  d_alu;
   logic [7:0]  d_ctl;
   logic        d_illegal, d_ebreak;
   logic        use_rs1, use_rs2, use_rd;
   logic        accept, handshake;

   assign opcode = in_inst[6:0];
   assign f3     = in_inst[14:12];
   assign f7     = in_inst[31:25];
   assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
   assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign imm_u  = {in_inst[31:12], 12'b0};
   assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21],
                    1'b0};

   always_comb begin
      alu_f3 = AluAdd;
      unique case (f3)
         3'b000: alu_f3 = AluAdd;
         3'b001: alu_f3 = AluSll;
         3'b010: alu_f3 = AluSlt;
         3'b011: alu_f3 = AluSltu;
         3'b100: alu_f3 = AluXor;
         3'b101: alu_f3 = f7[5] ? AluSra : AluSrl;
         3'b110: alu_f3 = AluOr;
         3'b111: alu_f3 = AluAnd;
      endcase
   end

   always_comb begin
      d_rs1     = in_inst[19:15];
      d_rs2     = in_inst[24:20];
      d_rd      = in_inst[11:7];
      d_imm     = '0;
      d_alu     = AluAdd;
      d_ctl     = '0;
      d_illegal = 1'b0;
      d_ebreak  = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      use_rd    = 1'b0;
      if (in_inst == 32'h0010_0073) begin
         // rs1 = a0 so the environment can read the exit code
         d_ebreak = 1'b1;
         d_rs1    = 5'd10;
         d_rs2    = '0;
         d_rd     = '0;
      end else begin
         unique case (opcode)
            OpImm: begin
               d_imm = imm_i; d_ctl = CtlRegWen | CtlSrc2Imm; d_alu = alu_f3;
               use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OpReg: begin
               d_ctl = CtlRegWen;
               d_alu = (f3 == 3'b000 && f7[5]) ? AluSub : alu_f3;
               use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
               d_illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OpLui: begin
               d_imm = imm_u; d_ctl = CtlRegWen | CtlSrc2Imm; d_alu = AluPassB; use_rd = 1'b1;
            end
            OpAuipc: begin
               d_imm = imm_u; d_ctl = CtlRegWen | CtlSrc1Pc | CtlSrc2Imm; use_rd = 1'b1;
            end
            OpJal: begin
               d_imm = imm_j; d_ctl = CtlRegWen | CtlSrc1Pc | CtlJump; use_rd = 1'b1;
            end
            OpJalr: begin
               d_imm = imm_i; d_ctl = CtlRegWen | CtlJump; use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OpBranch: begin
               d_imm = imm_b; d_ctl = CtlBranch; d_alu = AluSub; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OpLoad: begin
               d_imm = imm_i; d_ctl = CtlRegWen | CtlSrc2Imm | CtlMemRen | CtlMemToReg;
               use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OpStore: begin
               d_imm = imm_s; d_ctl = CtlMemWen | CtlSrc2Imm; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: d_illegal = 1'b1;
         endcase
      end
      // RV32E has only x0..x15
      if (NR_REG == 16 && ((use_rs1 && d_rs1[4]) || (use_rs2 && d_rs2[4]) || (use_rd && d_rd[4])))
         d_illegal = 1'b1;
      if (d_illegal) begin
         d_ctl = '0;
         d_imm = '0;
         d_alu = AluAdd;
      end
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      unique case (state_q)
         StEmpty: begin
            in_ready = !flush;
            if (in_valid && !flush) state_d = StFull;
         end
         StFull: begin
            in_ready = !flush && out_ready && !stop_sim;
            if (flush)          state_d = StEmpty;
            else if (out_ready) state_d = stop_sim ? StHalt : (in_valid ? StFull : StEmpty);
         end
         StHalt:  state_d = StHalt;
         default: state_d = StEmpty;
      endcase
   end

   assign out_valid = (state_q == StFull);
   assign halted    = (state_q == StHalt);
   assign accept    = in_valid & in_ready;
   assign handshake = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StEmpty;
         out_pc   <= '0;
         rs1      <= '0;
         rs2      <= '0;
         rd       <= '0;
         imm      <= '0;
         alu_op   <= '0;
         funct3   <= '0;
         ctl      <= '0;
         illegal  <= 1'b0;
         stop_sim <= 1'b0;
         dec_cnt  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            out_pc   <= in_pc;
            rs1      <= d_rs1;
            rs2      <= d_rs2;
            rd       <= d_rd;
            imm      <= d_imm;
            alu_op   <= d_alu;
            funct3   <= f3;
            ctl      <= d_ctl;
            illegal  <= d_illegal;
            stop_sim <= d_ebreak;
         end
         if (handshake) dec_cnt <= dec_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_idu_stage.sv
// Directed bench for idu_stage: expected bundles are queued on accept and checked on handshake.
module tb_idu_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, flush, out_ready;
   logic [31:0] in_inst, in_pc;

   logic        in_ready, out_valid, illegal, stop_sim, halted;
   logic [31:0] out_pc, imm, dec_cnt;
   logic [4:0]  rs1, rs2, rd;
   logic [3:0]  alu_op;
   logic [2:0]  funct3;
   logic [7:0]  ctl;

   logic        b_in_ready, b_out_valid, b_illegal, b_stop_sim, b_halted;
   logic [31:0] b_out_pc, b_imm, b_dec_cnt;
   logic [4:0]  b_rs1, b_rs2, b_rd;
   logic [3:0]  b_alu_op;
   logic [2:0]  b_funct3;
   logic [7:0]  b_ctl;

   idu_stage #(.NR_REG(16), .CNT_W(32)) u_e (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
      .funct3(funct3), .ctl(ctl), .illegal(illegal), .stop_sim(stop_sim), .halted(halted),
      .dec_cnt(dec_cnt)
   );

   idu_stage #(.NR_REG(32), .CNT_W(32)) u_i (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
      .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_pc(b_out_pc), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .imm(b_imm), .alu_op(b_alu_op),
      .funct3(b_funct3), .ctl(b_ctl), .illegal(b_illegal), .stop_sim(b_stop_sim),
      .halted(b_halted), .dec_cnt(b_dec_cnt)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  alu;
      logic [7:0]  ctl;
      logic [2:0]  f3;
      logic        ill, stp;
      logic [3:0]  care;  // {alu, rd, rs2, rs1}
   } exp_t;

   exp_t sb[$];
   exp_t nxt;
   exp_t e20[3];
   int   n_chk = 0;
   int   n_err = 0;

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] im, input logic [4:0] a,
                               input logic [4:0] b, input logic [4:0] d, input logic [3:0] alu,
                               input logic [7:0] c, input logic [2:0] f3, input logic ill,
                               input logic stp, input logic [3:0] care);
      exp_t e;
      e.pc = pc; e.imm = im; e.rs1 = a; e.rs2 = b; e.rd = d; e.alu = alu; e.ctl = c;
      e.f3 = f3; e.ill = ill; e.stp = stp; e.care = care;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic cmp_bundle(input exp_t e);
      chk("sb_pc", out_pc, e.pc);
      chk("sb_imm", imm, e.imm);
      chk("sb_ctl", 32'(ctl), 32'(e.ctl));
      chk("sb_funct3", 32'(funct3), 32'(e.f3));
      chk("sb_illegal", 32'(illegal), 32'(e.ill));
      chk("sb_stop_sim", 32'(stop_sim), 32'(e.stp));
      if (e.care[0]) chk("sb_rs1", 32'(rs1), 32'(e.rs1));
      if (e.care[1]) chk("sb_rs2", 32'(rs2), 32'(e.rs2));
      if (e.care[2]) chk("sb_rd", 32'(rd), 32'(e.rd));
      if (e.care[3]) chk("sb_alu_op", 32'(alu_op), 32'(e.alu));
   endtask

   // Settle, log accept/handshake against the scoreboard, then advance one cycle.
   task automatic tick();
      #1;
      if (in_valid && in_ready) sb.push_back(nxt);
      if (out_valid && out_ready) begin
         n_chk++;
         assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_pop: observed=empty queue expected=pending bundle");
         end
         if (sb.size() != 0) cmp_bundle(sb.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_halted"}, 32'(halted), 32'd0);
      chk({tag, "_stop_sim"}, 32'(stop_sim), 32'd0);
      chk({tag, "_illegal"}, 32'(illegal), 32'd0);
      chk({tag, "_ctl"}, 32'(ctl), 32'd0);
      chk({tag, "_imm"}, imm, 32'd0);
      chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
      chk({tag, "_rs1"}, 32'(rs1), 32'd0);
      chk({tag, "_rs2"}, 32'(rs2), 32'd0);
      chk({tag, "_rd"}, 32'(rd), 32'd0);
      chk({tag, "_out_pc"}, out_pc, 32'd0);
      chk({tag, "_dec_cnt"}, dec_cnt, 32'd0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
      #2;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // addi x1,x0,5
      nxt = mk(32'h100, 32'd5, 5'd0, 5'd0, 5'd1, 4'd0, 8'h05, 3'd0, 1'b0, 1'b0, 4'b1101);
      in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h100; out_ready = 1'b1;
      #1 chk("addi_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("addi_out_valid", 32'(out_valid), 32'd1);
      chk("addi_rd", 32'(rd), 32'd1);
      chk("addi_imm", imm, 32'd5);
      chk("addi_alu_op", 32'(alu_op), 32'd0);
      chk("addi_ctl", 32'(ctl), 32'h05);
      chk("addi_cnt0", dec_cnt, 32'd0);
      tick();
      chk("addi_drained", 32'(out_valid), 32'd0);
      chk("addi_cnt1", dec_cnt, 32'd1);

      // back-to-back: add x3,x1,x2 / sub x4,x3,x1 / beq x1,x2,+8
      do_reset();
      e20[0] = mk(32'h10, 32'd0, 5'd1, 5'd2, 5'd3, 4'd0, 8'h01, 3'd0, 1'b0, 1'b0, 4'b1111);
      e20[1] = mk(32'h14, 32'd0, 5'd3, 5'd1, 5'd4, 4'd1, 8'h01, 3'd0, 1'b0, 1'b0, 4'b1111);
      e20[2] = mk(32'h18, 32'd8, 5'd1, 5'd2, 5'd0, 4'd1, 8'h20, 3'd0, 1'b0, 1'b0, 4'b1011);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_inst = (i == 0) ? 32'h0020_81B3 : (i == 1) ? 32'h4011_8233 : 32'h0020_8463;
         in_pc = 32'h10 + 32'(4 * i);
         nxt = e20[i];
         #1 chk("b2b_in_ready", 32'(in_ready), 32'd1);
         if (i > 0) chk("b2b_out_valid", 32'(out_valid), 32'd1);
         tick();
      end
      in_valid = 1'b0;
      chk("b2b_last_valid", 32'(out_valid), 32'd1);
      tick();
      chk("b2b_drained", 32'(out_valid), 32'd0);
      chk("b2b_cnt", dec_cnt, 32'd3);

      // stall: srai x5,x6,3 held while jal x1,+16 waits
      nxt = mk(32'h40, 32'h403, 5'd6, 5'd0, 5'd5, 4'd7, 8'h05, 3'd5, 1'b0, 1'b0, 4'b1101);
      in_valid = 1'b1; in_inst = 32'h4033_5293; in_pc = 32'h40; out_ready = 1'b0;
      tick();
      nxt = mk(32'h44, 32'd16, 5'd0, 5'd0, 5'd1, 4'd0, 8'h43, 3'd0, 1'b0, 1'b0, 4'b0100);
      in_inst = 32'h0100_00EF; in_pc = 32'h44;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_pc", out_pc, 32'h40);
         chk("stall_imm", imm, 32'h403);
         chk("stall_alu_op", 32'(alu_op), 32'd7);
         chk("stall_cnt", dec_cnt, 32'd3);
         tick();
      end
      out_ready = 1'b1;
      #1 chk("release_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("release_out_valid", 32'(out_valid), 32'd1);
      chk("release_pc", out_pc, 32'h44);
      chk("release_cnt", dec_cnt, 32'd4);
      tick();
      chk("release_cnt_end", dec_cnt, 32'd5);

      // add x17,x1,x2 on RV32E vs RV32I, then an undefined opcode
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0020_88B3; in_pc = 32'h80;
      nxt = mk(32'h80, 32'd0, 5'd1, 5'd2, 5'd17, 4'd0, 8'h00, 3'd0, 1'b1, 1'b0, 4'b0111);
      tick();
      chk("e_x17_illegal", 32'(illegal), 32'd1);
      chk("e_x17_ctl", 32'(ctl), 32'd0);
      chk("i_x17_illegal", 32'(b_illegal), 32'd0);
      chk("i_x17_ctl", 32'(b_ctl), 32'h01);
      chk("i_x17_rd", 32'(b_rd), 32'd17);
      in_inst = 32'hFFFF_FFFF; in_pc = 32'h84;
      nxt = mk(32'h84, 32'd0, 5'd0, 5'd0, 5'd0, 4'd0, 8'h00, 3'd7, 1'b1, 1'b0, 4'b0000);
      tick();
      in_valid = 1'b0;
      chk("bad_op_illegal", 32'(illegal), 32'd1);
      chk("i_bad_op_illegal", 32'(b_illegal), 32'd1);
      chk("i_bad_op_imm", b_imm, 32'd0);
      tick();
      chk("illegal_not_halted", 32'(halted), 32'd0);
      chk("illegal_cnt", dec_cnt, 32'd2);
      chk("i_illegal_cnt", b_dec_cnt, 32'd2);

      // ebreak then addi: stage halts after handing ebreak over
      in_valid = 1'b1; in_inst = 32'h0010_0073; in_pc = 32'h200;
      nxt = mk(32'h200, 32'd0, 5'd10, 5'd0, 5'd0, 4'd0, 8'h00, 3'd0, 1'b0, 1'b1, 4'b0111);
      tick();
      in_inst = 32'h0050_0093; in_pc = 32'h204;
      nxt = mk(32'h204, 32'd5, 5'd0, 5'd0, 5'd1, 4'd0, 8'h05, 3'd0, 1'b0, 1'b0, 4'b1101);
      chk("ebreak_stop_sim", 32'(stop_sim), 32'd1);
      chk("ebreak_rs1", 32'(rs1), 32'd10);
      #1 chk("ebreak_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_out_valid", 32'(out_valid), 32'd0);
      chk("halt_cnt", dec_cnt, 32'd3);
      for (int i = 0; i < 3; i++) begin
         flush = (i == 1);
         #1 chk("halt_in_ready", 32'(in_ready), 32'd0);
         tick();
         chk("halt_sticky", 32'(halted), 32'd1);
      end
      flush = 1'b0; in_valid = 1'b0;
      chk("halt_sb_drained", 32'(sb.size()), 32'd0);
      rst = 1'b1;
      #1;
      chk("halt_rst_halted", 32'(halted), 32'd0);
      chk("halt_rst_stop_sim", 32'(stop_sim), 32'd0);
      chk("halt_rst_cnt", dec_cnt, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // flush while stalled, flush blocks accept, async reset mid-cycle
      out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h300;
      nxt = mk(32'h300, 32'd5, 5'd0, 5'd0, 5'd1, 4'd0, 8'h05, 3'd0, 1'b0, 1'b0, 4'b1101);
      tick();
      in_valid = 1'b0;
      chk("flush_pre_valid", 32'(out_valid), 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      sb.delete();
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_cnt", dec_cnt, 32'd0);
      flush = 1'b1; in_valid = 1'b1; in_pc = 32'h310;
      #1 chk("flush_blocks_accept", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      chk("flush_no_load", 32'(out_valid), 32'd0);
      nxt = mk(32'h310, 32'd5, 5'd0, 5'd0, 5'd1, 4'd0, 8'h05, 3'd0, 1'b0, 1'b0, 4'b1101);
      tick();
      in_valid = 1'b0;
      chk("rst_pre_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk_zero("mid_rst");
      sb.delete();
      rst = 1'b0;
      @(negedge clk);
      chk("final_sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/idu_stage.md
IDU_STAGE -- requirements
Module: idu_stage

Interface
REQ-001 SHALL provide parameter NR_REG, default 16, meaning architectural register count; legal values 16 (RV32E) and 32 (RV32I).
REQ-002 SHALL provide parameter CNT_W, default 32, meaning width of the decoded-instruction counter.
REQ-003 SHALL have the following ports; the clock is single and the reset is asynchronous, active-high:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  IFU offers an instruction.
- in_ready  out  1  stage accepts the offer.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction address.
- flush  in  1  discard held instruction.
- out_valid  out  1  decoded bundle valid to EXU.
- out_ready  in  1  EXU accepts bundle.
- out_pc  out  32  registered PC.
- rs1, rs2, rd  out  5 each  register indices.
- imm  out  32  sign-extended immediate.
- alu_op  out  4  ALU operation.
- funct3  out  3  inst[14:12].
- ctl  out  8  control flags; bit map in REQ-009.
- illegal  out  1  held instruction is illegal.
- stop_sim  out  1  held instruction is ebreak.
- halted  out  1  stage in HALT state.
- dec_cnt  out  CNT_W  count of bundles handed to EXU.

Function
REQ-004 SHALL use states EMPTY, FULL and HALT, with one output register set (latency 1 cycle, in_inst accepted -> out_valid next cycle).
REQ-005 SHALL drive in_ready = (state==EMPTY) | (state==FULL & out_ready & !stop_sim), and 0 in HALT; it SHALL accept on in_valid & in_ready.
REQ-006 SHALL transition as follows:
- EMPTY + accept -> FULL.
- FULL + out_ready + no accept -> EMPTY.
- FULL + out_ready + accept -> FULL, with the new bundle loaded in the same cycle (back-to-back, no bubble).
- FULL + !out_ready -> hold all outputs stable.
REQ-007 SHALL, in FULL with stop_sim=1 and out_ready=1, go to HALT; HALT is left only by rst.
REQ-008 SHALL drive out_valid=1 exactly in FULL, and SHALL keep all bundle outputs stable whenever out_valid=1 and out_ready=0.
REQ-009 SHALL map ctl as follows:
- [0] reg_wen.
- [1] src1_pc (ALU A = pc).
- [2] src2_imm (ALU B = imm).
- [3] mem_ren.
- [4] mem_wen.
- [5] branch.
- [6] jump.
- [7] memtoreg (= mem_ren).
REQ-010 SHALL encode alu_op as follows: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10.
REQ-011 SHALL decode by opcode as follows:
- OP-IMM 0010011: immI, src2_imm, reg_wen; alu_op from funct3, SRAI when funct7[5].
- OP 0110011: reg_wen; SUB/SRA when funct7[5].
- LUI 0110111: immU, PASSB.
- AUIPC 0010111: immU, src1_pc, ADD.
- JAL 1101111: immJ, src1_pc, jump, reg_wen.
- JALR 1100111: immI, jump, reg_wen.
- BRANCH 1100011: immB, branch, SUB.
- LOAD 0000011: immI, mem_ren, reg_wen, ADD.
- STORE 0100011: immS, mem_wen, ADD.
REQ-012 SHALL decode inst==0x00100073 as ebreak: stop_sim=1, rs1=10 (a0 exit code), rs2=0, rd=0, ctl=0, imm=0.
REQ-013 SHALL set illegal=1, ctl=0 and imm=0 for any other opcode, for wrong funct7 on OP, and when NR_REG=16 and any used register index has bit4 set.
REQ-014 SHALL forward illegal instructions downstream as ordinary bundles; the stage SHALL NOT halt on them.
REQ-015 SHALL, on flush, force the state to EMPTY next cycle with no accept that cycle (in_ready=0 while flush); flush in HALT SHALL have no effect.
REQ-016 SHALL increment dec_cnt on every out_valid & out_ready handshake and wrap modulo 2^CNT_W.

Reset
REQ-017 SHALL, on rst, immediately set state EMPTY, out_valid=0, halted=0, stop_sim=0, illegal=0, ctl=0, imm=0, alu_op=0, rs1=rs2=rd=0, out_pc=0, dec_cnt=0, independent of clk.
REQ-018 SHALL, on rst asserted mid-FULL or in HALT, drop the held bundle without an output handshake.

Verification
REQ-019 SHALL be covered by: addi x1,x0,5 (0x00500093) with out_ready=1 -> next cycle out_valid=1, rd=1, imm=5, alu_op=0, ctl=0x05, dec_cnt 0->1.
REQ-020 SHALL be covered by: three back-to-back valid instructions with out_ready=1 -> three consecutive out_valid cycles, in_ready constantly 1, dec_cnt=3.
REQ-021 SHALL be covered by: out_ready held 0 for 4 cycles with a bundle held -> outputs unchanged, in_ready=0; release -> handshake plus new accept in the same cycle.
REQ-022 SHALL be covered by: NR_REG=16 with add x17,x1,x2 -> illegal=1, ctl=0; the same instruction with NR_REG=32 -> illegal=0, ctl=0x01.
REQ-023 SHALL be covered by: ebreak then addi offered -> stop_sim=1, rs1=10; after handshake halted=1, in_ready=0 permanently; rst -> halted=0.
REQ-024 SHALL be covered by: flush while FULL and out_ready=0 -> out_valid=0 next cycle, dec_cnt unchanged; rst asserted mid-cycle -> outputs zero before the next clk edge.
